// File: rtl/signed_divider.sv
// Sequential 8-bit signed restoring divider: one shift-subtract step per clock, 10-cycle latency.
// Optional multiplexed hex display built only when DIV_HEX_DISPLAY_EN is defined.
module signed_divider #(
   parameter int unsigned REFRESH_BITS = 16
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       Load_B,
   input  logic       Execute,
   input  logic [7:0] Din,
   output logic [7:0] Qval,
   output logic [7:0] Rval,
   output logic [7:0] Bval,
   output logic       Done,
   output logic       DivZero,
   output logic       Ovf,
   output logic [7:0] hex_seg,
   output logic [3:0] hex_grid
);

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StIter,
      StFix,
      StHold
   } state_e;

   state_e     r_state;
   state_e     w_state_next;

   logic [7:0] r_dvd;
   logic [7:0] r_bval;
   logic [7:0] r_q;
   logic [8:0] r_a;
   logic [2:0] r_cnt;
   logic       r_qsign;
   logic       r_rsign;
   logic [7:0] r_qval;
   logic [7:0] r_rval;
   logic       r_divzero;
   logic       r_ovf;

   logic [7:0] w_dmag;
   logic [7:0] w_bmag;
   logic [9:0] w_a_sh;
   logic [7:0] w_q_sh;
   logic       w_ge;
   logic [8:0] w_diff;
   logic       w_divzero;
   logic       w_ovf;

   // Two's-complement magnitude on 8 bits; -128 maps to 0x80, read as unsigned.
   assign w_dmag = r_dvd[7] ? -r_dvd : r_dvd;
   assign w_bmag = r_bval[7] ? -r_bval : r_bval;

   assign w_a_sh = {r_a, r_q[7]};
   assign w_q_sh = {r_q[6:0], 1'b0};
   assign w_ge   = (w_a_sh >= {2'b00, w_bmag});
   assign w_diff = w_a_sh[8:0] - {1'b0, w_bmag};

   assign w_divzero = (r_bval == 8'h00);
   assign w_ovf     = (r_dvd == 8'h80) && (r_bval == 8'hFF);

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle:  if (Execute) w_state_next = StLoad;
         StLoad:  w_state_next = StIter;
         StIter:  if (r_cnt == 3'd7) w_state_next = StFix;
         StFix:   w_state_next = StHold;
         StHold:  if (!Execute) w_state_next = StIdle;
         default: w_state_next = StIdle;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         r_dvd     <= 8'h00;
         r_bval    <= 8'h00;
         r_q       <= 8'h00;
         r_a       <= 9'h000;
         r_cnt     <= 3'd0;
         r_qsign   <= 1'b0;
         r_rsign   <= 1'b0;
         r_qval    <= 8'h00;
         r_rval    <= 8'h00;
         r_divzero <= 1'b0;
         r_ovf     <= 1'b0;
      end else begin
         unique case (r_state)
            StIdle: begin
               // Divisor is written on the same edge that starts a run, so LOAD sees the new value.
               if (Load_B) r_bval <= Din;
               if (Execute) r_dvd <= Din;
            end
            StLoad: begin
               r_q     <= w_dmag;
               r_a     <= 9'h000;
               r_cnt   <= 3'd0;
               r_qsign <= r_dvd[7] ^ r_bval[7];
               r_rsign <= r_dvd[7];
            end
            StIter: begin
               r_cnt <= r_cnt + 3'd1;
               if (w_ge) begin
                  r_a <= w_diff;
                  r_q <= {w_q_sh[7:1], 1'b1};
               end else begin
                  r_a <= w_a_sh[8:0];
                  r_q <= w_q_sh;
               end
            end
            StFix: begin
               r_divzero <= w_divzero;
               r_ovf     <= w_ovf;
               if (w_divzero) begin
                  r_qval <= 8'hFF;
                  r_rval <= r_dvd;
               end else if (w_ovf) begin
                  r_qval <= 8'h80;
                  r_rval <= 8'h00;
               end else begin
                  r_qval <= r_qsign ? -r_q : r_q;
                  r_rval <= r_rsign ? -r_a[7:0] : r_a[7:0];
               end
            end
            default: ;
         endcase
      end
   end

   assign Qval    = r_qval;
   assign Rval    = r_rval;
   assign Bval    = r_bval;
   assign Done    = (r_state == StHold);
   assign DivZero = r_divzero;
   assign Ovf     = r_ovf;

`ifdef DIV_HEX_DISPLAY_EN
   logic [REFRESH_BITS-1:0] r_refresh;
   logic [1:0]              r_digit;
   logic [7:0]              r_seg;
   logic [3:0]              r_grid;
   logic [3:0]              w_nibble;
   logic [6:0]              w_seg7;
   logic                    w_dp_n;

   always_comb begin
      w_nibble = r_rval[3:0];
      unique case (r_digit)
         2'd3:    w_nibble = r_qval[7:4];
         2'd2:    w_nibble = r_qval[3:0];
         2'd1:    w_nibble = r_rval[7:4];
         default: w_nibble = r_rval[3:0];
      endcase
   end

   // Active-high gfedcba codes, inverted for the active-low display.
   always_comb begin
      w_seg7 = 7'h00;
      unique case (w_nibble)
         4'h0: w_seg7 = 7'h3F;
         4'h1: w_seg7 = 7'h06;
         4'h2: w_seg7 = 7'h5B;
         4'h3: w_seg7 = 7'h4F;
         4'h4: w_seg7 = 7'h66;
         4'h5: w_seg7 = 7'h6D;
         4'h6: w_seg7 = 7'h7D;
         4'h7: w_seg7 = 7'h07;
         4'h8: w_seg7 = 7'h7F;
         4'h9: w_seg7 = 7'h6F;
         4'hA: w_seg7 = 7'h77;
         4'hB: w_seg7 = 7'h7C;
         4'hC: w_seg7 = 7'h39;
         4'hD: w_seg7 = 7'h5E;
         4'hE: w_seg7 = 7'h79;
         default: w_seg7 = 7'h71;
      endcase
   end

   assign w_dp_n = ~((r_digit == 2'd0) && (r_divzero || r_ovf));

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         r_refresh <= '0;
         r_digit   <= 2'd0;
         r_seg     <= 8'hFF;
         r_grid    <= 4'hF;
      end else begin
         r_refresh <= r_refresh + {{(REFRESH_BITS - 1){1'b0}}, 1'b1};
         if (&r_refresh) r_digit <= r_digit + 2'd1;
         r_seg  <= {w_dp_n, ~w_seg7};
         r_grid <= ~(4'b0001 << r_digit);
      end
   end

   assign hex_seg  = r_seg;
   assign hex_grid = r_grid;
`else
   logic [REFRESH_BITS-1:0] w_unused_refresh;
   assign w_unused_refresh = '0;
   assign hex_seg  = 8'hFF;
   assign hex_grid = 4'hF;
`endif

endmodule

// File: tb/tb_signed_divider.sv
// Directed self-checking bench for signed_divider: signed cases, divide-by-zero, overflow,
// held Execute, mid-run reset and ignored controls during a run.
module tb_signed_divider;

   logic       Clk = 1'b0;
   logic       Reset = 1'b0;
   logic       Load_B = 1'b0;
   logic       Execute = 1'b0;
   logic [7:0] Din = 8'h00;
   logic [7:0] Qval;
   logic [7:0] Rval;
   logic [7:0] Bval;
   logic       Done;
   logic       DivZero;
   logic       Ovf;
   logic [7:0] hex_seg;
   logic [3:0] hex_grid;

   int errors = 0;
   int checks = 0;

   signed_divider #(
      .REFRESH_BITS(16)
   ) u_dut (
      .Clk     (Clk),
      .Reset   (Reset),
      .Load_B  (Load_B),
      .Execute (Execute),
      .Din     (Din),
      .Qval    (Qval),
      .Rval    (Rval),
      .Bval    (Bval),
      .Done    (Done),
      .DivZero (DivZero),
      .Ovf     (Ovf),
      .hex_seg (hex_seg),
      .hex_grid(hex_grid)
   );

   always #5 Clk = ~Clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic load_b(input logic [7:0] val);
      @(negedge Clk);
      Load_B = 1'b1;
      Din    = val;
      tick();
      @(negedge Clk);
      Load_B = 1'b0;
      check("bval load", {24'h0, Bval}, {24'h0, val});
   endtask

   // One run; lb also asserts Load_B on the start edge, hold keeps Execute high extra cycles.
   task automatic run(input string tag, input logic lb, input logic [7:0] din,
                      input logic [7:0] eq, input logic [7:0] er, input logic ez,
                      input logic eo, input int hold);
      int drops;
      drops = 0;
      @(negedge Clk);
      Execute = 1'b1;
      Load_B  = lb;
      Din     = din;
      tick();                       // edge 0
      @(negedge Clk);
      Load_B = 1'b0;
      repeat (9) tick();            // edges 1..9
      check($sformatf("%s done early", tag), {31'h0, Done}, 32'h0);
      tick();                       // edge 10
      check($sformatf("%s done", tag), {31'h0, Done}, 32'h1);
      check($sformatf("%s qval", tag), {24'h0, Qval}, {24'h0, eq});
      check($sformatf("%s rval", tag), {24'h0, Rval}, {24'h0, er});
      check($sformatf("%s divzero", tag), {31'h0, DivZero}, {31'h0, ez});
      check($sformatf("%s ovf", tag), {31'h0, Ovf}, {31'h0, eo});
      if (hold > 0) begin
         repeat (hold) begin
            tick();
            if (Done !== 1'b1) drops++;
         end
         check($sformatf("%s done held", tag), drops, 0);
         check($sformatf("%s qval held", tag), {24'h0, Qval}, {24'h0, eq});
      end
      @(negedge Clk);
      Execute = 1'b0;
      tick();
      check($sformatf("%s done release", tag), {31'h0, Done}, 32'h0);
      check($sformatf("%s qval kept", tag), {24'h0, Qval}, {24'h0, eq});
   endtask

   initial begin
      repeat (3) tick();
      check("rst qval", {24'h0, Qval}, 32'h0);
      check("rst rval", {24'h0, Rval}, 32'h0);
      check("rst bval", {24'h0, Bval}, 32'h0);
      check("rst flags", {29'h0, Done, DivZero, Ovf}, 32'h0);
      check("rst seg", {24'h0, hex_seg}, 32'hFF);
      check("rst grid", {28'h0, hex_grid}, 32'hF);
      @(negedge Clk);
      Reset = 1'b1;
      tick();

      load_b(8'h07);
      run("neg dividend", 1'b0, 8'hC5, 8'hF8, 8'hFD, 1'b0, 1'b0, 0);
      load_b(8'hF9);
      run("neg divisor", 1'b0, 8'h3B, 8'hF8, 8'h03, 1'b0, 1'b0, 0);
      load_b(8'h00);
      run("div zero", 1'b0, 8'h64, 8'hFF, 8'h64, 1'b1, 1'b0, 0);
      load_b(8'hFF);
      run("overflow", 1'b0, 8'h80, 8'h80, 8'h00, 1'b0, 1'b1, 0);
      load_b(8'h02);
      run("min by two", 1'b0, 8'h80, 8'hC0, 8'h00, 1'b0, 1'b0, 0);
      run("both pressed", 1'b1, 8'h0D, 8'h01, 8'h00, 1'b0, 1'b0, 0);
      check("both pressed bval", {24'h0, Bval}, 32'h0D);

      load_b(8'h07);
      run("held", 1'b0, 8'h64, 8'h0E, 8'h02, 1'b0, 1'b0, 30);
      run("press again", 1'b0, 8'hC5, 8'hF8, 8'hFD, 1'b0, 1'b0, 0);

      // Reset during ITER count 4.
      @(negedge Clk);
      Execute = 1'b1;
      Din     = 8'h3B;
      tick();                       // edge 0
      repeat (5) tick();            // edges 1..5, counter now 4
      @(negedge Clk);
      Reset   = 1'b0;
      Execute = 1'b0;
      tick();
      check("midrst qval", {24'h0, Qval}, 32'h0);
      check("midrst rval", {24'h0, Rval}, 32'h0);
      check("midrst bval", {24'h0, Bval}, 32'h0);
      check("midrst flags", {29'h0, Done, DivZero, Ovf}, 32'h0);
      @(negedge Clk);
      Reset = 1'b1;
      repeat (12) tick();
      check("midrst no done", {31'h0, Done}, 32'h0);

      // Controls pulsed during ITER must be ignored.
      load_b(8'h07);
      @(negedge Clk);
      Execute = 1'b1;
      Din     = 8'h64;
      tick();                       // edge 0
      @(negedge Clk);
      Execute = 1'b0;
      tick();                       // edge 1
      tick();                       // edge 2
      @(negedge Clk);
      Load_B  = 1'b1;
      Execute = 1'b1;
      Din     = 8'h55;
      tick();                       // edge 3
      @(negedge Clk);
      Load_B  = 1'b0;
      Execute = 1'b0;
      repeat (6) tick();            // edges 4..9
      check("ignore done early", {31'h0, Done}, 32'h0);
      tick();                       // edge 10
      check("ignore done", {31'h0, Done}, 32'h1);
      check("ignore qval", {24'h0, Qval}, 32'h0E);
      check("ignore rval", {24'h0, Rval}, 32'h02);
      check("ignore bval", {24'h0, Bval}, 32'h07);
      tick();
      check("ignore done drop", {31'h0, Done}, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
